// File: rtl/dmem_arb_pkg.sv
// Shared types and MemWrite encodings for the data-memory arbiter.
// Fairness is built in only when DMEM_ARB_FAIRNESS_EN is defined (see dmem_arbiter).
package dmem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    localparam logic [1:0] MW_READ = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of debug grants that left a waiting CPU ungranted.
// hit is high once the count reaches MAX; clr wins over inc.
module dmem_arb_starve_ctr #(
    parameter int unsigned MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int unsigned W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the dmem port between the CPU and the debug controller (debug priority, optional lock).
// Define DMEM_ARB_FAIRNESS_EN to let a starved CPU win one access after STARVE_MAX debug grants.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [1:0]        cpu_we,
    input  logic [2:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic [1:0]        dbg_we,
    input  logic [2:0]        dbg_size,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_lock,
    output logic [1:0]        mem_we,
    output logic [2:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked
);

    // Handshake: a requester holds req and its command until it sees gnt in
    // the same cycle; a granted read returns rvalid/rdata exactly one cycle later.

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("dmem_arbiter: STARVE_MAX must be at least 1");
    end

    arb_state_t state_q, state_d;
    owner_t     rd_owner_q, rd_owner_d;
    logic       rd_pend_q, rd_pend_d;
    logic       hold_lock;
    logic       fair_hit;

`ifdef DMEM_ARB_FAIRNESS_EN
    dmem_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (dbg_gnt && cpu_req),
        .clr   (cpu_gnt || !cpu_req),
        .hit   (fair_hit)
    );
`else
    assign fair_hit = 1'b0;
`endif

    always_comb begin
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        mem_we     = MW_READ;
        mem_size   = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        // A held lock ignores fairness; dropping the lock arbitrates normally at once.
        hold_lock  = (state_q == LOCKED) && dbg_lock;

        if (!reset) begin
            if (hold_lock) begin
                dbg_gnt = dbg_req;
            end else if (dbg_req && !(fair_hit && cpu_req)) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end

        if (dbg_gnt) begin
            mem_we     = dbg_we;
            mem_size   = dbg_size;
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
            rd_owner_d = OWN_DBG;
            rd_pend_d  = (dbg_we == MW_READ);
        end else if (cpu_gnt) begin
            mem_we     = cpu_we;
            mem_size   = cpu_size;
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
            rd_owner_d = OWN_CPU;
            rd_pend_d  = (cpu_we == MW_READ);
        end

        state_d = (dbg_lock && ((state_q == LOCKED) || dbg_gnt)) ? LOCKED : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CPU;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign cpu_rvalid = rd_pend_q && (rd_owner_q == OWN_CPU);
    assign dbg_rvalid = rd_pend_q && (rd_owner_q == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;

    localparam int SM = 8;
    localparam int RW = 33;
`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cpu_req, dbg_req, dbg_lock;
    logic [1:0]  cpu_we, dbg_we;
    logic [2:0]  cpu_size, dbg_size;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, locked;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic [1:0]  mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (SM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_size   (cpu_size),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_size   (dbg_size),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .dbg_lock   (dbg_lock),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .locked     (locked)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory stand-in: read-only image, 1-cycle registered read ----------------
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    always @(posedge clk) mem_rdata <= rd_word(mem_addr);

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];   // {owner_is_dbg, data} for the response due next cycle
    bit m_locked = 1'b0;
    int m_cnt = 0;

    // Observations captured at the check point of the last tick.
    logic        obs_cpu_gnt, obs_dbg_gnt, obs_locked, obs_cpu_rv, obs_dbg_rv;
    logic [1:0]  obs_mem_we;
    logic [31:0] obs_mem_addr, obs_cpu_rd, obs_dbg_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven (just after a rising edge).
    task automatic tick();
        bit          e_cg, e_dg, starve, e_crv, e_drv;
        logic [1:0]  e_we;
        logic [2:0]  e_sz;
        logic [31:0] e_ad, e_wd, e_crd, e_drd;
        logic [RW-1:0] e;
        e_cg = 0; e_dg = 0; e_crv = 0; e_drv = 0;
        e_we = 2'b00; e_sz = 3'd0; e_ad = 32'd0; e_wd = 32'd0; e_crd = 32'd0; e_drd = 32'd0;

        if (reset) begin
            m_locked = 0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            starve = FAIR && (m_cnt >= SM) && cpu_req;
            if (m_locked && dbg_lock) e_dg = dbg_req;
            else if (dbg_req && !starve) e_dg = 1;
            else if (cpu_req) e_cg = 1;
        end
        if (e_dg) begin e_we = dbg_we; e_sz = dbg_size; e_ad = dbg_addr; e_wd = dbg_wdata; end
        if (e_cg) begin e_we = cpu_we; e_sz = cpu_size; e_ad = cpu_addr; e_wd = cpu_wdata; end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[32]) begin e_drv = 1; e_drd = e[31:0]; end
            else begin e_crv = 1; e_crd = e[31:0]; end
        end

        @(negedge clk);
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(e_dg));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_size", 32'(mem_size), 32'(e_sz));
        chk("mem_addr", mem_addr, e_ad);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("locked", 32'(locked), 32'(m_locked));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e_drv));
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("dbg_rdata", dbg_rdata, e_drd);
        obs_cpu_gnt = cpu_gnt; obs_dbg_gnt = dbg_gnt; obs_locked = locked;
        obs_cpu_rv = cpu_rvalid; obs_dbg_rv = dbg_rvalid; obs_mem_we = mem_we;
        obs_mem_addr = mem_addr; obs_cpu_rd = cpu_rdata; obs_dbg_rd = dbg_rdata;

        @(posedge clk);
        if (!reset) begin
            if ((e_dg || e_cg) && e_we == 2'b00) exp_q.push_back({e_dg, rd_word(e_ad)});
            m_locked = dbg_lock && (m_locked || e_dg);
            if (e_cg || !cpu_req) m_cnt = 0;
            else if (e_dg && m_cnt < SM) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    // ---------------- driver helpers ----------------
    task automatic drive_cpu(input bit r, input logic [1:0] we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_size = 3'($urandom_range(0, 4));
    endtask

    task automatic drive_dbg(input bit r, input logic [1:0] we, input logic [31:0] a, input logic [31:0] d, input bit l);
        dbg_req = r; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_lock = l; dbg_size = 3'($urandom_range(0, 4));
    endtask

    // ---------------- directed then random sequence ----------------
    initial begin
        int n_cpu;
        reset = 1'b1;
        drive_cpu(0, 2'b00, 32'h0, 32'h0);
        drive_dbg(0, 2'b00, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;

        // Reset with requests present: nothing granted, everything 0.
        drive_cpu(1, 2'b00, 32'h20, 32'h0);
        drive_dbg(1, 2'b00, 32'h24, 32'h0, 1);
        tick();
        chk("rst_cpu_gnt", 32'(obs_cpu_gnt), 32'd0);
        chk("rst_locked", 32'(obs_locked), 32'd0);
        reset = 1'b0;
        drive_cpu(0, 2'b00, 32'h0, 32'h0);
        drive_dbg(0, 2'b00, 32'h0, 32'h0, 0);
        tick();

        // CPU-only read of 0x10.
        drive_cpu(1, 2'b00, 32'h10, 32'h0);
        tick();
        chk("tp_cpu_rd_gnt", 32'(obs_cpu_gnt), 32'd1);
        drive_cpu(0, 2'b00, 32'h0, 32'h0);
        tick();
        chk("tp_cpu_rvalid", 32'(obs_cpu_rv), 32'd1);
        chk("tp_cpu_rdata", obs_cpu_rd, 32'hDEAD_BEEF);
        chk("tp_dbg_rvalid_quiet", 32'(obs_dbg_rv), 32'd0);

        // Simultaneous CPU word write and debug read: debug first.
        drive_cpu(1, 2'b11, 32'h8, 32'h1234_5678);
        drive_dbg(1, 2'b00, 32'h4, 32'h0, 0);
        tick();
        chk("tp_sim_dbg_gnt", 32'(obs_dbg_gnt), 32'd1);
        chk("tp_sim_addr_dbg", obs_mem_addr, 32'h4);
        drive_dbg(0, 2'b00, 32'h0, 32'h0, 0);
        tick();
        chk("tp_sim_cpu_gnt", 32'(obs_cpu_gnt), 32'd1);
        chk("tp_sim_we_cpu", 32'(obs_mem_we), 32'd3);
        chk("tp_sim_addr_cpu", obs_mem_addr, 32'h8);

        // Lock: acquire, then three locked accesses with the CPU waiting, then release.
        drive_cpu(1, 2'b00, 32'h30, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive_dbg(1, 2'(i & 1), 32'h40 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1);
            tick();
            chk("tp_lock_cpu_gnt", 32'(obs_cpu_gnt), 32'd0);
            if (i > 0) chk("tp_lock_locked", 32'(obs_locked), 32'd1);
        end
        drive_dbg(0, 2'b00, 32'h0, 32'h0, 0);
        tick();
        chk("tp_unlock_cpu_gnt", 32'(obs_cpu_gnt), 32'd1);
        drive_cpu(0, 2'b00, 32'h0, 32'h0);
        tick();
        chk("tp_unlocked", 32'(obs_locked), 32'd0);

        // Both requesters held for 100 cycles.
        n_cpu = 0;
        drive_cpu(1, 2'b01, 32'h50, 32'hAA);
        drive_dbg(1, 2'b10, 32'h54, 32'hBB, 0);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (obs_cpu_gnt) n_cpu++;
        end
        chk("tp_contention_cpu_grants", 32'(n_cpu), FAIR ? 32'd11 : 32'd0);
        drive_cpu(0, 2'b00, 32'h0, 32'h0);
        drive_dbg(0, 2'b00, 32'h0, 32'h0, 0);
        tick();

        // Reset the cycle after a locking debug read.
        drive_dbg(1, 2'b00, 32'h60, 32'h0, 1);
        tick();
        drive_dbg(0, 2'b00, 32'h0, 32'h0, 1);
        reset = 1'b1;
        tick();
        chk("tp_rst_dbg_rvalid", 32'(obs_dbg_rv), 32'd0);
        chk("tp_rst_locked", 32'(obs_locked), 32'd0);
        reset = 1'b0;
        drive_dbg(0, 2'b00, 32'h0, 32'h0, 0);
        tick();

        // Alternating CPU and debug reads every cycle.
        for (int i = 0; i < 12; i++) begin
            drive_cpu((i % 2) == 0, 2'b00, 32'h100 + 32'(i * 4), 32'h0);
            drive_dbg((i % 2) == 1, 2'b00, 32'h200 + 32'(i * 4), 32'h0, 0);
            tick();
        end
        drive_cpu(0, 2'b00, 32'h0, 32'h0);
        drive_dbg(0, 2'b00, 32'h0, 32'h0, 0);
        tick();

        // Randomized traffic; the CPU keeps its command until granted.
        for (int i = 0; i < 400; i++) begin
            if (!(cpu_req && !obs_cpu_gnt))
                drive_cpu($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                          32'($urandom_range(0, 63)) << 2, $urandom);
            drive_dbg($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                      32'($urandom_range(0, 63)) << 2, $urandom, $urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;
        drive_cpu(0, 2'b00, 32'h0, 32'h0);
        drive_dbg(0, 2'b00, 32'h0, 32'h0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
